// File: rtl/vram_dualport_ctl.sv
// vram_dualport_ctl
//   Single-clock VDP video RAM with a CPU port and an independent video read port.
//   The CPU port works through an auto-incrementing address pointer and a
//   read-ahead latch. After reset, a built-in clear engine fills the whole array
//   with CLEAR_VALUE.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   CLEAR  | clear engine owns the write port, sweeping clr_ptr 0..max
//   IDLE   | accepting one CPU request per cycle (load > wr > rd)
//   FETCH  | one-cycle prefetch: latch <= ram[ptr], ptr++
//
// Ports
//   clk            single clock, all logic on posedge
//   reset          synchronous, active-high
//   cpu_addr_load  load pointer from cpu_addr_in, then prefetch
//   cpu_addr_in    new pointer value
//   cpu_wr         write cpu_din at pointer, pointer++
//   cpu_din        write data
//   cpu_rd         consume read-ahead latch, prefetch next word
//   cpu_dout       read-ahead latch contents
//   cpu_busy       CPU requests are ignored while high
//   clr_busy       clear sweep running
//   vid_addr       video read address, sampled every cycle
//   vid_dout       video read data (latency 1, or 2 with OUT_REG)
module vram_dualport_ctl #(
    parameter int                 ADDR_W         = 14,
    parameter int                 DATA_W         = 8,
    parameter int                 OUT_REG        = 0,
    parameter int                 CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0]  CLEAR_VALUE    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_addr_load,
    input  logic [ADDR_W-1:0] cpu_addr_in,
    input  logic              cpu_wr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_rd,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_busy,
    output logic              clr_busy,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_dout
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic [ADDR_W-1:0] clr_ptr, clr_ptr_nx;
    logic [DATA_W-1:0] latch;
    logic              do_fetch;
    logic              latch_from_wr;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] vid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            ptr     <= '0;
            clr_ptr <= '0;
            latch   <= '0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            clr_ptr <= clr_ptr_nx;
            if (do_fetch)
                latch <= ram[ptr];
            else if (latch_from_wr)
                latch <= cpu_din;
        end
    end

    always_comb begin
        state_nx      = state;
        ptr_nx        = ptr;
        clr_ptr_nx    = clr_ptr;
        ram_we        = 1'b0;
        ram_waddr     = ptr;
        ram_wdata     = cpu_din;
        do_fetch      = 1'b0;
        latch_from_wr = 1'b0;
        case (state)
            ST_CLEAR: begin
                ram_we     = 1'b1;
                ram_waddr  = clr_ptr;
                ram_wdata  = CLEAR_VALUE;
                clr_ptr_nx = clr_ptr + 1'b1;
                if (&clr_ptr)
                    state_nx = ST_IDLE;
            end
            ST_IDLE: begin
                if (cpu_addr_load) begin
                    ptr_nx   = cpu_addr_in;
                    state_nx = ST_FETCH;
                end else if (cpu_wr) begin
                    ram_we        = 1'b1;
                    latch_from_wr = 1'b1;
                    ptr_nx        = ptr + 1'b1;
                end else if (cpu_rd) begin
                    state_nx = ST_FETCH;
                end
            end
            ST_FETCH: begin
                do_fetch = 1'b1;
                ptr_nx   = ptr + 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        // A reset cycle must never disturb array contents.
        if (reset)
            ram_we = 1'b0;
    end

    assign cpu_dout = latch;
    assign cpu_busy = (state != ST_IDLE);
    assign clr_busy = (state == ST_CLEAR);

    // Write port; reads below sample the pre-write value (read-before-write).
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            vid_q <= '0;
        else
            vid_q <= ram[vid_addr];
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] vid_q2;
            always_ff @(posedge clk) begin
                if (reset)
                    vid_q2 <= '0;
                else
                    vid_q2 <= vid_q;
            end
            assign vid_dout = vid_q2;
        end else begin : g_no_out_reg
            assign vid_dout = vid_q;
        end
    endgenerate

endmodule
